hist2d_iq_binner: RTL and testbench

// Front end of the 2D histogram path. Accepts raw signed I/Q samples and

---
 rtl/hist2d_iq_binner.sv | 135 +++++++++++++
 tb/tb_hist2d_iq_binner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hist2d_iq_binner.sv
// hist2d_iq_binner: converts signed I/Q samples to clipped (i,q) bin coordinates with a restoring divider
// Ports:
//   clk100, reset                 clock and async active-high reset
//   arm                           clear counters and start an acquisition
//   sample_valid/sample_ready     sample handshake (ready only while acquiring and idle)
//   i_sample, q_sample            signed samples
//   i_min, q_min                  signed lower edge of bin 0
//   i_bin_width, q_bin_width      unsigned bin widths
//   i_bin_num, q_bin_num          bin counts
//   num_data_pts                  points per acquisition
//   data_in                       1-cycle strobe, coordinates valid
//   i_bin_coord, q_bin_coord      bin indices, held until the next strobe
//   clip_flag                     last emitted point clipped on either axis
//   pts_binned, drop_count        emitted points / samples refused while busy
//   acq_done                      acquisition complete
module hist2d_iq_binner #(
  parameter int DATA_W = 16,
  parameter int BIN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk100,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic signed [DATA_W-1:0] q_sample,
  input  logic signed [DATA_W-1:0] i_min,
  input  logic signed [DATA_W-1:0] q_min,
  input  logic        [DATA_W-1:0] i_bin_width,
  input  logic        [DATA_W-1:0] q_bin_width,
  input  logic        [BIN_W-1:0]  i_bin_num,
  input  logic        [BIN_W-1:0]  q_bin_num,
  input  logic        [CNT_W-1:0]  num_data_pts,
  output logic                     data_in,
  output logic        [BIN_W-1:0]  i_bin_coord,
  output logic        [BIN_W-1:0]  q_bin_coord,
  output logic                     clip_flag,
  output logic        [CNT_W-1:0]  pts_binned,
  output logic        [CNT_W-1:0]  drop_count,
  output logic                     acq_done
);
  localparam int CW = $clog2(DATA_W) + 1;
  typedef enum logic [2:0] {IDLE, ACQ, DIV, EMIT, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] i_rem, q_rem, i_quo, q_quo;
  logic i_neg, q_neg;
  logic [CW-1:0] cnt;
  logic [DATA_W:0] i_off, q_off;
  logic [2*DATA_W-1:0] i_nxt, q_nxt;
  logic [BIN_W:0] i_res, q_res;

  // One restoring step: the quotient register starts as the dividend and
  // shifts quotient bits in from the right as dividend bits leave the left.
  function automatic logic [2*DATA_W-1:0] step(input logic [DATA_W-1:0] rem, quo, d);
    logic [DATA_W:0] r2;
    r2 = {rem, quo[DATA_W-1]};
    return (r2 >= {1'b0, d}) ? {r2[DATA_W-1:0] - d, quo[DATA_W-2:0], 1'b1}
                             : {r2[DATA_W-1:0], quo[DATA_W-2:0], 1'b0};
  endfunction

  // Returns {clipped, coord}.
  function automatic logic [BIN_W:0] clip(input logic neg, input logic [DATA_W-1:0] quo, d,
                                          input logic [BIN_W-1:0] n);
    return (neg || n == '0) ? {1'b1, {BIN_W{1'b0}}}
         : (d == '0 || quo >= DATA_W'(n)) ? {1'b1, n - 1'b1}
         : {1'b0, quo[BIN_W-1:0]};
  endfunction

  always_comb begin
    i_off = {i_sample[DATA_W-1], i_sample} - {i_min[DATA_W-1], i_min};
    q_off = {q_sample[DATA_W-1], q_sample} - {q_min[DATA_W-1], q_min};
    i_nxt = step(i_rem, i_quo, i_bin_width);
    q_nxt = step(q_rem, q_quo, q_bin_width);
    // Clip from the final step's result so coordinates are ready on entry to EMIT.
    i_res = clip(i_neg, i_nxt[DATA_W-1:0], i_bin_width, i_bin_num);
    q_res = clip(q_neg, q_nxt[DATA_W-1:0], q_bin_width, q_bin_num);
    sample_ready = state == ACQ;
    data_in = state == EMIT;
    acq_done = state == DONE;
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      i_rem <= '0;
      q_rem <= '0;
      i_quo <= '0;
      q_quo <= '0;
      i_neg <= 1'b0;
      q_neg <= 1'b0;
      cnt <= '0;
      i_bin_coord <= '0;
      q_bin_coord <= '0;
      clip_flag <= 1'b0;
      pts_binned <= '0;
      drop_count <= '0;
    end else if (arm) begin
      state <= (num_data_pts == '0) ? DONE : ACQ;
      pts_binned <= '0;
      drop_count <= '0;
    end else begin
      if ((state == DIV || state == EMIT) && sample_valid && drop_count != '1)
        drop_count <= drop_count + 1'b1;
      case (state)
        ACQ: if (sample_valid) begin
          i_rem <= '0;
          q_rem <= '0;
          i_quo <= i_off[DATA_W-1:0];
          q_quo <= q_off[DATA_W-1:0];
          i_neg <= i_off[DATA_W];
          q_neg <= q_off[DATA_W];
          cnt <= '0;
          state <= DIV;
        end
        DIV: begin
          {i_rem, i_quo} <= i_nxt;
          {q_rem, q_quo} <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) begin
            i_bin_coord <= i_res[BIN_W-1:0];
            q_bin_coord <= q_res[BIN_W-1:0];
            clip_flag <= i_res[BIN_W] | q_res[BIN_W];
            state <= EMIT;
          end
        end
        EMIT: begin
          pts_binned <= pts_binned + 1'b1;
          state <= (pts_binned + 1'b1 == num_data_pts) ? DONE : ACQ;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hist2d_iq_binner.sv
// tb_hist2d_iq_binner: directed bench with a timeline model of the binner
module tb_hist2d_iq_binner;
  logic clk100 = 1'b0;
  logic reset = 1'b1;
  logic arm = 1'b0;
  logic sample_valid = 1'b0;
  logic sample_ready;
  logic signed [15:0] i_sample = '0, q_sample = '0;
  logic signed [15:0] i_min = -16'sd1000, q_min = -16'sd1000;
  logic [15:0] i_bin_width = 16'd200, q_bin_width = 16'd200;
  logic [7:0] i_bin_num = 8'd10, q_bin_num = 8'd10;
  logic [15:0] num_data_pts = 16'd100;
  logic data_in, clip_flag, acq_done;
  logic [7:0] i_bin_coord, q_bin_coord;
  logic [15:0] pts_binned, drop_count;

  int passed = 0, total = 0, pulses = 0;
  bit m_active = 0, m_done = 0;
  int m_busy = 0, m_pts = 0, m_drops = 0, e_i = 0, e_q = 0;

  hist2d_iq_binner dut (
    .clk100(clk100), .reset(reset), .arm(arm), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .i_sample(i_sample), .q_sample(q_sample),
    .i_min(i_min), .q_min(q_min), .i_bin_width(i_bin_width), .q_bin_width(q_bin_width),
    .i_bin_num(i_bin_num), .q_bin_num(q_bin_num), .num_data_pts(num_data_pts),
    .data_in(data_in), .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .clip_flag(clip_flag), .pts_binned(pts_binned), .drop_count(drop_count),
    .acq_done(acq_done)
  );

  always #5 clk100 = ~clk100;

  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
  endtask

  // Expected bin with clip marker in bit 16, from plain integer division.
  function automatic int binf(int s, int mn, int w, int n);
    int off, q;
    off = s - mn;
    if (off < 0 || n == 0) return 1 << 16;
    if (w == 0) return (n - 1) | (1 << 16);
    q = off / w;
    return (q >= n) ? ((n - 1) | (1 << 16)) : q;
  endfunction

  // Timeline model: an accepted sample opens a busy window of 17 cycles
  // whose last cycle carries the strobe.
  always @(posedge clk100 or posedge reset) begin
    if (reset) begin
      m_active <= 0; m_done <= 0; m_busy <= 0; m_pts <= 0; m_drops <= 0;
    end else if (arm) begin
      m_pts <= 0; m_drops <= 0; m_busy <= 0;
      m_done <= num_data_pts == 0; m_active <= num_data_pts != 0;
    end else if (m_active) begin
      if (m_busy == 0) begin
        if (sample_valid) begin
          m_busy <= 17;
          e_i <= binf(int'(i_sample), int'(i_min), int'(i_bin_width), int'(i_bin_num));
          e_q <= binf(int'(q_sample), int'(q_min), int'(q_bin_width), int'(q_bin_num));
        end
      end else begin
        if (sample_valid && m_drops < 65535) m_drops <= m_drops + 1;
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_pts <= m_pts + 1;
          if (m_pts + 1 == int'(num_data_pts)) begin
            m_active <= 0; m_done <= 1;
          end
        end
      end
    end
  end

  always @(negedge clk100) begin
    if (data_in) pulses++;
    if (!reset) begin
      chk("ready", sample_ready, m_active && m_busy == 0);
      chk("data_in", data_in, m_busy == 1);
      if (data_in && m_busy == 1) begin
        chk("i_coord", i_bin_coord, e_i & 255);
        chk("q_coord", q_bin_coord, e_q & 255);
        chk("clip", clip_flag, ((e_i | e_q) >> 16) & 1);
      end
      chk("pts", pts_binned, m_pts);
      chk("drops", drop_count, m_drops);
      chk("done", acq_done, m_done);
    end
  end

  task automatic do_arm();
    @(negedge clk100) arm = 1;
    @(negedge clk100) arm = 0;
  endtask

  task automatic zeros(input string n);
    chk({n, "_ready"}, sample_ready, 0);
    chk({n, "_data_in"}, data_in, 0);
    chk({n, "_coords"}, {i_bin_coord, q_bin_coord}, 0);
    chk({n, "_clip"}, clip_flag, 0);
    chk({n, "_pts"}, pts_binned, 0);
    chk({n, "_drops"}, drop_count, 0);
    chk({n, "_done"}, acq_done, 0);
  endtask

  task automatic send(input int si, input int sq, input int ei, input int eq, input int ec);
    int k;
    k = 0;
    while (!sample_ready && k < 100) begin @(negedge clk100); k++; end
    if (!sample_ready) chk("ready_timeout", 0, 1);
    i_sample = 16'(si); q_sample = 16'(sq); sample_valid = 1;
    @(negedge clk100);
    sample_valid = 0; i_sample = 16'h7abc; q_sample = 16'h8123;
    k = 1;
    while (!data_in && k < 40) begin @(negedge clk100); k++; end
    chk("latency", k, 17);
    chk("i_lit", i_bin_coord, ei);
    chk("q_lit", q_bin_coord, eq);
    chk("clip_lit", clip_flag, ec);
  endtask

  initial begin
    int p0, k;
    repeat (3) @(negedge clk100);
    zeros("reset");
    #2 reset = 0;
    @(negedge clk100);
    chk("idle_ready", sample_ready, 0);
    do_arm();
    send(-1000, -1, 0, 4, 0);
    send(-1, 999, 4, 9, 0);
    send(999, -1000, 9, 0, 0);
    send(-800, -801, 1, 0, 0);
    send(-2000, 0, 0, 5, 1);
    send(5000, 0, 9, 5, 1);
    i_bin_width = 0;
    send(0, 0, 9, 5, 1);
    i_bin_width = 200; i_bin_num = 0;
    send(0, 0, 0, 5, 1);
    i_bin_num = 10;
    do_arm();
    p0 = pulses;
    sample_valid = 1;
    repeat (60) @(negedge clk100);
    sample_valid = 0;
    k = 0;
    while (!sample_ready && k < 40) begin @(negedge clk100); k++; end
    chk("hold_pulses", pulses - p0, 4);
    chk("hold_drops", drop_count, 56);
    chk("hold_pts", pts_binned, 4);
    num_data_pts = 4;
    do_arm();
    for (int n = 0; n < 4; n++) send(-1000, -1, 0, 4, 0);
    @(negedge clk100);
    chk("done_lit", acq_done, 1);
    chk("done_pts", pts_binned, 4);
    p0 = pulses;
    sample_valid = 1;
    repeat (5) @(negedge clk100);
    sample_valid = 0;
    chk("done_ignored_pulses", pulses - p0, 0);
    chk("done_ignored_drops", drop_count, 0);
    do_arm();
    chk("rearm_pts", pts_binned, 0);
    chk("rearm_drops", drop_count, 0);
    chk("rearm_done", acq_done, 0);
    num_data_pts = 0;
    do_arm();
    chk("zero_pts_done", acq_done, 1);
    num_data_pts = 100;
    do_arm();
    i_sample = 16'sd300; sample_valid = 1;
    @(negedge clk100) sample_valid = 0;
    repeat (5) @(negedge clk100);
    #2 reset = 1;
    #1 zeros("async");
    p0 = pulses;
    repeat (2) @(negedge clk100);
    #2 reset = 0;
    repeat (30) @(negedge clk100);
    chk("reset_no_pulse", pulses - p0, 0);
    do_arm();
    i_sample = 16'sd300; sample_valid = 1;
    @(negedge clk100) sample_valid = 0;
    repeat (5) @(negedge clk100);
    do_arm();
    chk("abort_ready", sample_ready, 1);
    p0 = pulses;
    repeat (25) @(negedge clk100);
    chk("abort_no_pulse", pulses - p0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
